clock_sequencer: RTL
====================

# clock_sequencer

Run-control block that sits between the board clock/reset pins and the design. After power-up or a RESET press it holds the design in reset for a fixed number of clock-enabled cycles. It then gates the design's clock enable in one of four modes: free run, slow (power-of-two divided), single step from a debounced push-button, or halt. It replaces the ad-hoc divided-clock approach with one clock domain plus a clock enable, so BRAM start-up settling and cycle-by-cycle observation are handled in one place.

## Interface
- DIV_W, 5: width of `div`; slow-mode period is 2^div cycles, up to 2^31.
- DEBOUNCE_W, 16: width of the button debounce counter.
- RESET_W, 12: width of the start-up reset counter.
- CLK  in  1  board clock; single clock domain.
- RESET  in  1  asynchronous, active-high reset; clears all state immediately.
- mode  in  2  00 RUN, 01 SLOW, 10 STEP, 11 HALT; sampled every CLK edge.
- div  in  DIV_W  slow-mode exponent; sampled every CLK edge.
- step_btn  in  1  raw, asynchronous, bouncing push-button; active-high.
- clk_en  out  1  registered clock enable for the design.
- resetn  out  1  registered active-low reset for the design.
- step_count  out  16  number of `clk_en` pulses issued while `resetn`=1; wraps.

## Operation
- **Reset values** (RESET=1): clk_en=0, resetn=0, step_count=0, reset counter=0, prescaler=0, sync flops=0, debounced level=0, debounce counter=0.
- **State HOLD** (entered on reset):
  - Reset counter increments by 1 per edge.
  - clk_en=1 on every edge, so synchronous resets in the design see clocks.
  - When the counter equals all-ones, go to ACTIVE and set resetn=1 on that edge.
  - The counter is not cleared on the transition.
  - HOLD never returns except via RESET.
- **State ACTIVE**:
  - resetn stays 1.
  - clk_en for the next cycle is chosen by mode:
    - RUN: clk_en=1.
    - SLOW: clk_en=1 iff (prescaler & mask)==mask, where mask=(1<<div)-1 and the prescaler is 32 bits. div=0 gives clk_en=1 every cycle.
    - STEP: clk_en=1 for exactly one cycle per rising edge of the debounced button level.
    - HALT: clk_en=0.
- **Prescaler**:
  - Free-running from reset.
  - Never cleared on mode or div change.
  - After entering SLOW, the first pulse comes at the next alignment point.
- **Button path**:
  - 2-flop synchronizer, then a debouncer.
  - Debounce counter clears when the synchronized level equals the debounced level.
  - Otherwise it increments.
  - When it is all-ones and the levels still differ, the debounced level flips and the counter clears.
- **Rising edges outside STEP**: detected and discarded; never queued.
- **Edges during HOLD**: discarded.
- **step_count**: increments on every edge where clk_en=1 and resetn=1. Wraps 0xFFFF→0x0000.
- **Mode change mid-operation**: takes effect on the next edge. A STEP pulse already registered in clk_en completes its single cycle.
- **RESET mid-operation**: asynchronously forces the reset values, including a restart of HOLD.

## Timing
- HOLD length: resetn rises on the 2^RESET_W−1-th CLK edge after RESET falls.
- clk_en is 1 during each of those 2^RESET_W−1 cycles (from the first edge onward).
- Mode/div to clk_en latency: 1 cycle (registered output).
- SLOW period: exactly 2^div cycles, with a one-cycle pulse width.
- Button latency, from the first stable sample on step_btn to clk_en:
  - 2 cycles synchronizer
  - plus 2^DEBOUNCE_W cycles debounce
  - plus 1 cycle edge detect and register.
- A press shorter than 2^DEBOUNCE_W cycles produces no pulse.
- A bounce resets the debounce count.
- A new STEP pulse needs release and re-press. Each side of the release/re-press must be held stable for the full debounce interval.

## Test plan
- **Start-up**: RESET high for 3 cycles then low, RESET_W=4, mode=RUN → resetn rises at the 15th edge; clk_en=1 on all 15 HOLD cycles and after; step_count=0 at rise, then +1 per cycle.
- **SLOW**: mode=SLOW, div=3 → clk_en pulses of width 1 every 8 cycles; change div to 0 → clk_en=1 every cycle from the next edge.
- **STEP, clean press**: mode=STEP, DEBOUNCE_W=4, step_btn held 40 cycles → exactly one clk_en pulse, 19 cycles after press onset; step_count +1.
- **STEP, bounce**: press with 10-cycle glitches repeating for 100 cycles, then stable → still exactly one pulse; 10-cycle press alone → no pulse; press in RUN then switch to STEP → no pulse.
- **HALT and wrap**: step_count preset by 65535 RUN pulses, one more pulse → 0x0000; mode=HALT → clk_en=0 and step_count frozen.
- **Mid-operation reset**: assert RESET asynchronously between edges while in SLOW → clk_en=0, resetn=0, step_count=0 immediately; HOLD restarts with a full count.

Source files
------------

// File: rtl/clock_sequencer_if.sv
// rtl/clock_sequencer_if.sv - run-control bus between board-side controls and the design
// Purpose: groups the mode/div/button controls and the clk_en/resetn/step_count
//   outputs of clock_sequencer into one bundle.
// Ports (signals):
//   mode       [1:0]       00 RUN, 01 SLOW, 10 STEP, 11 HALT
//   div        [DIV_W-1:0] slow-mode exponent, period 2^div
//   step_btn               raw bouncing push-button, active-high
//   clk_en                 registered clock enable for the design
//   resetn                 registered active-low reset for the design
//   step_count [15:0]      clk_en pulses issued while resetn=1, wraps
// Modports: master drives the controls, slave is the sequencer.
interface clock_sequencer_if #(
  parameter int DIV_W = 5
);
  logic [1:0]       mode;
  logic [DIV_W-1:0] div;
  logic             step_btn;
  logic             clk_en;
  logic             resetn;
  logic [15:0]      step_count;

  modport master (
    output mode, div, step_btn,
    input  clk_en, resetn, step_count
  );

  modport slave (
    input  mode, div, step_btn,
    output clk_en, resetn, step_count
  );
endinterface

// File: rtl/clock_sequencer.sv
// rtl/clock_sequencer.sv - start-up reset hold plus RUN/SLOW/STEP/HALT clock-enable gating
// Purpose: holds the design in reset for 2^RESET_W-1 enabled cycles after RESET,
//   then gates clk_en by mode in a single clock domain.
// Ports:
//   CLK    in  board clock
//   RESET  in  asynchronous active-high reset, clears all state
//   bus    slave modport of clock_sequencer_if (mode, div, step_btn in;
//          clk_en, resetn, step_count out)
// Parameters: DEBOUNCE_W debounce counter width, RESET_W start-up counter width.
module clock_sequencer #(
  parameter int DEBOUNCE_W = 16,
  parameter int RESET_W    = 12
) (
  input logic              CLK,
  input logic              RESET,
  clock_sequencer_if.slave bus
);

  typedef enum logic {HOLD, ACTIVE} state_t;

  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_SLOW = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;
  localparam logic [1:0] MODE_HALT = 2'b11;

  // The counter reaches all-ones on the edge that releases resetn, so the
  // release decision is taken while it still holds all-ones minus one.
  localparam logic [RESET_W-1:0] RST_LAST = {{(RESET_W-1){1'b1}}, 1'b0};

  state_t                state;
  logic [RESET_W-1:0]    rst_cnt;
  logic [31:0]           prescaler;
  logic                  sync1;
  logic                  sync2;
  logic                  db_level;
  logic                  db_prev;
  logic [DEBOUNCE_W-1:0] db_cnt;
  logic                  clk_en_q;
  logic                  resetn_q;
  logic [15:0]           step_cnt_q;

  logic [31:0] slow_mask;
  logic        slow_hit;
  logic        btn_rise;

  assign slow_mask = (32'd1 << bus.div) - 32'd1;
  assign slow_hit  = (prescaler & slow_mask) == slow_mask;
  assign btn_rise  = db_level & ~db_prev;

  assign bus.clk_en     = clk_en_q;
  assign bus.resetn     = resetn_q;
  assign bus.step_count = step_cnt_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= HOLD;
      rst_cnt    <= '0;
      prescaler  <= '0;
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      db_level   <= 1'b0;
      db_prev    <= 1'b0;
      db_cnt     <= '0;
      clk_en_q   <= 1'b0;
      resetn_q   <= 1'b0;
      step_cnt_q <= '0;
    end else begin
      prescaler <= prescaler + 32'd1;

      sync1 <= bus.step_btn;
      sync2 <= sync1;

      // Any disagreement shorter than a full counter wrap restarts the count.
      db_prev <= db_level;
      if (sync2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == '1) begin
        db_level <= ~db_level;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + DEBOUNCE_W'(1);
      end

      if (clk_en_q && resetn_q) begin
        step_cnt_q <= step_cnt_q + 16'd1;
      end

      case (state)
        HOLD: begin
          rst_cnt  <= rst_cnt + RESET_W'(1);
          clk_en_q <= 1'b1;
          if (rst_cnt == RST_LAST) begin
            state    <= ACTIVE;
            resetn_q <= 1'b1;
          end
        end
        ACTIVE: begin
          resetn_q <= 1'b1;
          // Button rises seen in any other mode are simply dropped here.
          case (bus.mode)
            MODE_RUN:  clk_en_q <= 1'b1;
            MODE_SLOW: clk_en_q <= slow_hit;
            MODE_STEP: clk_en_q <= btn_rise;
            MODE_HALT: clk_en_q <= 1'b0;
            default:   clk_en_q <= 1'b0;
          endcase
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule
